systolic_drain_requant: RTL and testbench
=========================================

Name: systolic_drain_requant

Overview:
- Downstream stage of the dense systolic array. Consumes the flat INT32 accumulator matrix, N_ROWS×N_COLS in row-major order with 32 bits per entry.
- On `start`, snapshots the whole matrix into an internal bank, so the array may clear and begin the next tile the following cycle.
- Streams one requantized INT8 row per beat over a valid/ready interface to the output buffer / writeback path.
- Requantization per element: multiply by `scale`, round, arithmetic shift right by `shift`, saturate to INT8, optional ReLU.

Parameters:
- N_ROWS, 14, number of accumulator rows (one output beat per row).
- N_COLS, 14, accumulators per row (INT8 lanes per beat).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  capture c_in_flat and config, then begin draining; ignored while busy
- c_in_flat  in  N_ROWS*N_COLS*32  signed INT32 accumulators, entry (r,c) at bits [(r*N_COLS+c)*32 +: 32]
- scale  in  16  unsigned requant multiplier, latched on start
- shift  in  5  right-shift amount 0..31, latched on start
- relu_en  in  1  clamp negative results to 0, latched on start
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat
- out_data  out  N_COLS*8  signed INT8 lanes, lane c at [c*8 +: 8]
- out_row  out  $clog2(N_ROWS) (min 1)  row index of the current beat
- out_last  out  1  current beat is row N_ROWS-1
- busy  out  1  drain in progress
- done  out  1  single-cycle pulse when the last beat is accepted

Behaviour:
- Reset (async, rst_n low):
  - State IDLE.
  - out_valid, out_last, busy and done = 0; out_data = 0; out_row = 0.
  - Pipeline valid bits cleared.
  - Snapshot bank contents are don't-care.
  - Reset mid-drain aborts the tile with no done pulse.
- FSM states: IDLE, RUN.
  - IDLE, start=1: at that edge, load the snapshot bank from c_in_flat, latch scale/shift/relu_en, zero the issue row counter, set busy=1, go RUN.
  - RUN: start is ignored. Leave RUN on the edge where out_valid & out_ready & out_last; on that edge busy→0 and done=1 for exactly one cycle.
  - start in the same cycle that done is high is accepted, because the FSM is already IDLE.
- Pipeline: two stages, P1 then output register OR. Both advance together on adv = !out_valid | out_ready.
  - P1, on adv while rows remain to issue: per lane, prod = signed(acc) × unsigned(scale) as a 49-bit signed value; tag with the row index; increment the issue counter.
  - OR, on adv: load from P1. Per lane:
    - if shift>0, add 2^(shift-1) (round half up, toward +inf), computed in 49 bits with no overflow;
    - arithmetic shift right by shift;
    - saturate to [-128, 127];
    - if relu_en, clamp negatives to 0.
  - OR also loads out_row from the P1 tag, sets out_last = (tag == N_ROWS-1), and out_valid = P1 valid.
- Latency: start sampled at edge E0. Row 0 enters P1 at E1, and out_valid rises after E2 when out_ready is held high. Throughput is one row per cycle; N_ROWS beats total.
- Handshake:
  - While out_valid=1 and out_ready=0, out_data, out_row and out_last hold stable and no stage advances.
  - out_valid never deasserts without acceptance.
  - Rows are emitted strictly in order 0..N_ROWS-1 with no gaps other than backpressure.
- Snapshot isolation: changes on c_in_flat, scale, shift and relu_en after E0 do not affect the current tile.
- Width rules:
  - Extreme case: acc = -2^31, scale = 65535 gives a product within 49 bits signed.
  - Rounding add happens before the shift.
  - Saturation compares the full-width shifted value.

Test Plan:
- Identity: scale=1, shift=0, relu_en=0, acc(r,c)=r*N_COLS+c-100, out_ready=1 → 14 beats on consecutive cycles, first out_valid 2 cycles after the start edge. Lane values equal acc saturated to [-128,127] (e.g. 95 stays 95, entries ≥128 give 127). out_last only on row 13; done pulses once as row 13 is accepted.
- Rounding/shift: acc=5/6/-5/-6/7, scale=1, shift=2 → 1/2/-1/-1/2; acc=1000, scale=3, shift=4 → 188 saturates to 127; acc=-1000, scale=3, shift=4 → -128; relu_en=1 with acc=-50, shift=0 → 0.
- Backpressure: random out_ready (about 40% duty) → out_data/out_row hold while stalled, no row dropped or duplicated, rows arrive 0..13, done after the final accepted beat only.
- Snapshot isolation and start-while-busy: change c_in_flat and scale on the cycle after start, and pulse start mid-drain → output reflects only the captured tile; the extra start is ignored (exactly 14 beats, one done).
- Back-to-back: start asserted in the done cycle with a new matrix → second tile drains fully with correct values, busy stays high from its start edge.
- Reset mid-drain: assert rst_n=0 after row 5 is accepted → out_valid, busy and done go 0 immediately (async). After release, a new start drains a full 14 rows from row 0.

Source files
------------

// File: rtl/systolic_drain_requant.sv
// Drain stage for the systolic array: snapshots the INT32 accumulator tile on start,
// then streams one requantized INT8 row per beat (scale, round, shift, saturate, ReLU).
module systolic_drain_requant #(
  parameter int N_ROWS = 14,
  parameter int N_COLS = 14,
  localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [N_ROWS*N_COLS*32-1:0] c_in_flat,
  input  logic [15:0]                scale,
  input  logic [4:0]                 shift,
  input  logic                       relu_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_COLS*8-1:0]        out_data,
  output logic [RW-1:0]              out_row,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);

  localparam int CW = $clog2(N_ROWS + 1);
  localparam int PW = 49;
  localparam logic signed [PW-1:0] ONE    = PW'(1);
  localparam logic signed [PW-1:0] SAT_HI = PW'(127);
  localparam logic signed [PW-1:0] SAT_LO = -PW'(128);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e                state_q, state_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic [CW-1:0]         issue_q, issue_d;
  logic [31:0]           bank_q [N_ROWS][N_COLS];
  logic [31:0]           bank_d [N_ROWS][N_COLS];
  logic [15:0]           scale_q, scale_d;
  logic [4:0]            shift_q, shift_d;
  logic                  relu_q, relu_d;
  logic                  p1_valid_q, p1_valid_d;
  logic [RW-1:0]         p1_row_q, p1_row_d;
  logic signed [PW-1:0]  p1_prod_q [N_COLS];
  logic signed [PW-1:0]  p1_prod_d [N_COLS];
  logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [N_COLS*8-1:0]   out_data_q, out_data_d;
  logic [RW-1:0]         out_row_q, out_row_d;
  logic                  adv;

  // Signed INT32 times unsigned 16-bit scale; 49 bits holds -2^31 * 65535 exactly.
  function automatic logic signed [PW-1:0] widen_mul(input logic [31:0] acc, input logic [15:0] scl);
    logic signed [PW-1:0] a, s;
    a = {{(PW-32){acc[31]}}, acc};
    s = {{(PW-16){1'b0}}, scl};
    return a * s;
  endfunction

  function automatic logic [7:0] requant(input logic signed [PW-1:0] prod,
                                         input logic [4:0] sh, input logic relu);
    logic signed [PW-1:0] rnd, shd;
    logic [7:0]           res;
    rnd = (sh != 5'd0) ? (ONE << (sh - 5'd1)) : '0;
    shd = (prod + rnd) >>> sh;
    if (shd > SAT_HI)      res = 8'h7f;
    else if (shd < SAT_LO) res = 8'h80;
    else                   res = shd[7:0];
    if (relu && res[7]) res = 8'h00;
    return res;
  endfunction

  assign adv = !out_valid_q || out_ready;

  // NOTE: every _d gets its current value first so no path through this block infers a latch.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    issue_d     = issue_q;
    bank_d      = bank_q;
    scale_d     = scale_q;
    shift_d     = shift_q;
    relu_d      = relu_q;
    p1_valid_d  = p1_valid_q;
    p1_row_d    = p1_row_q;
    p1_prod_d   = p1_prod_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_last_d  = out_last_q;

    case (state_q)
      S_IDLE: if (start) begin
        for (int r = 0; r < N_ROWS; r++)
          for (int c = 0; c < N_COLS; c++)
            bank_d[r][c] = c_in_flat[(r*N_COLS + c)*32 +: 32];
        scale_d = scale;
        shift_d = shift;
        relu_d  = relu_en;
        issue_d = '0;
        busy_d  = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: if (out_valid_q && out_ready && out_last_q) begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      p1_valid_d = (state_q == S_RUN) && (issue_q < CW'(N_ROWS));
      if (p1_valid_d) begin
        for (int c = 0; c < N_COLS; c++)
          p1_prod_d[c] = widen_mul(bank_q[RW'(issue_q)][c], scale_q);
        p1_row_d = RW'(issue_q);
        issue_d  = issue_q + CW'(1);
      end
      out_valid_d = p1_valid_q;
      out_row_d   = p1_row_q;
      out_last_d  = p1_valid_q && (p1_row_q == RW'(N_ROWS - 1));
      for (int c = 0; c < N_COLS; c++)
        out_data_d[c*8 +: 8] = requant(p1_prod_q[c], shift_q, relu_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      issue_q     <= '0;
      p1_valid_q  <= 1'b0;
      p1_row_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      issue_q     <= issue_d;
      p1_valid_q  <= p1_valid_d;
      p1_row_q    <= p1_row_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_last_q  <= out_last_d;
    end
  end

  // NOTE: the snapshot bank and datapath payload are left unreset; they are only read behind valid/busy.
  always_ff @(posedge clk) begin
    bank_q    <= bank_d;
    scale_q   <= scale_d;
    shift_q   <= shift_d;
    relu_q    <= relu_d;
    p1_prod_q <= p1_prod_d;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_systolic_drain_requant.sv
// Directed bench for systolic_drain_requant: identity, rounding/saturation, backpressure,
// snapshot isolation, back-to-back tiles and reset mid-drain.
module tb_systolic_drain_requant;

  localparam int NR = 14;
  localparam int NC = 14;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic [NR*NC*32-1:0]   c_in_flat = '0;
  logic [15:0]           scale = '0;
  logic [4:0]            shift = '0;
  logic                  relu_en = 1'b0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic [NC*8-1:0]       out_data;
  logic [3:0]            out_row;
  logic                  out_last;
  logic                  busy;
  logic                  done;

  int          total = 0;
  int          bad = 0;
  int          acc_m [NR][NC];
  int unsigned cfg_scale;
  int          cfg_shift;
  bit          cfg_relu;
  logic [NC*8-1:0] got [NR];
  int          first_valid;
  int          rows_got;
  bit          done_seen;

  always #5 clk = ~clk;

  systolic_drain_requant #(.N_ROWS(NR), .N_COLS(NC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .c_in_flat(c_in_flat),
    .scale(scale), .shift(shift), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_last(out_last), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_lane(input int acc, input int unsigned sc, input int sh, input bit relu);
    longint v;
    v = longint'(acc) * longint'(sc);
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
    v = v >>> sh;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    if (relu && v < 0) v = 0;
    return v[7:0];
  endfunction

  function automatic logic [NC*8-1:0] exp_row(input int r);
    logic [NC*8-1:0] e;
    for (int c = 0; c < NC; c++) e[c*8 +: 8] = ref_lane(acc_m[r][c], cfg_scale, cfg_shift, cfg_relu);
    return e;
  endfunction

  task automatic zero_matrix();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) acc_m[r][c] = 0;
  endtask

  // Drives the tile and pulses start for one edge; returns on the negedge after that edge.
  task automatic launch(input int unsigned sc, input int sh, input bit rl);
    cfg_scale = sc;
    cfg_shift = sh;
    cfg_relu  = rl;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) c_in_flat[(r*NC + c)*32 +: 32] = acc_m[r][c];
    scale   = sc[15:0];
    shift   = sh[4:0];
    relu_en = rl;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Collects beats until done (or stop_after rows when stopping early); bounded by a cycle budget.
  task automatic drain(input int ready_pct, input int stop_after, input int start_iter);
    logic [NC*8-1:0] prev_data;
    logic [3:0]      prev_row;
    bit              stalled;
    stalled     = 1'b0;
    prev_data   = '0;
    prev_row    = '0;
    rows_got    = 0;
    done_seen   = 1'b0;
    first_valid = -1;
    for (int iter = 0; iter < 400; iter++) begin
      if (stalled) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, prev_data);
        check("hold_row", out_row, prev_row);
      end
      if (done) begin
        check("done_after_last", rows_got, NR);
        done_seen = 1'b1;
        break;
      end
      check("busy_high", busy, 1'b1);
      if (out_valid && first_valid < 0) first_valid = iter;
      out_ready = ($urandom_range(0, 99) < ready_pct);
      start     = (iter == start_iter);
      if (out_valid && out_ready) begin
        check("row_order", out_row, rows_got);
        check("row_data", out_data, exp_row(rows_got));
        check("row_last", out_last, rows_got == NR - 1);
        got[rows_got] = out_data;
        rows_got++;
        stalled = 1'b0;
      end else begin
        stalled   = out_valid;
        prev_data = out_data;
        prev_row  = out_row;
      end
      if (stop_after < NR && rows_got == stop_after) break;
      @(negedge clk);
    end
    start = 1'b0;
    if (stop_after >= NR) check("drain_done_seen", done_seen, 1'b1);
    check("rows_accepted", rows_got, stop_after);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_data", out_data, '0);
    check("rst_row", out_row, 4'd0);
    check("rst_last", out_last, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Identity pass-through, ready held high
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) acc_m[r][c] = r*NC + c - 100;
    launch(1, 0, 0);
    drain(100, NR, -1);
    check("id_latency", first_valid, 2);
    check("id_r0c0", got[0][7:0], 8'h9c);
    check("id_r7c0", got[7][7:0], 8'hfe);
    check("id_r13c13", got[13][13*8 +: 8], 8'd95);
    @(negedge clk);
    check("id_done_one_cycle", done, 1'b0);
    check("id_busy_low", busy, 1'b0);

    // Round half up then shift
    zero_matrix();
    acc_m[0][0] = 5; acc_m[0][1] = 6; acc_m[0][2] = -5; acc_m[0][3] = -6; acc_m[0][4] = 7;
    launch(1, 2, 0);
    drain(100, NR, -1);
    check("rnd_5", got[0][7:0], 8'd1);
    check("rnd_6", got[0][15:8], 8'd2);
    check("rnd_m5", got[0][23:16], 8'hff);
    check("rnd_m6", got[0][31:24], 8'hff);
    check("rnd_7", got[0][39:32], 8'd2);
    check("rnd_zero", got[5], '0);
    @(negedge clk);

    // Saturation after scale/shift
    zero_matrix();
    acc_m[0][0] = 1000; acc_m[0][1] = -1000;
    launch(3, 4, 0);
    drain(100, NR, -1);
    check("sat_pos", got[0][7:0], 8'h7f);
    check("sat_neg", got[0][15:8], 8'h80);
    @(negedge clk);

    // Extreme operands exercise the full product width
    zero_matrix();
    acc_m[0][0] = int'(32'h8000_0000); acc_m[0][1] = int'(32'h7fff_ffff); acc_m[0][2] = 200;
    launch(65535, 31, 0);
    drain(100, NR, -1);
    check("ext_min", got[0][7:0], 8'h80);
    check("ext_max", got[0][15:8], 8'h7f);
    check("ext_small", got[0][23:16], 8'h00);
    @(negedge clk);

    // ReLU
    zero_matrix();
    acc_m[0][0] = -50; acc_m[0][1] = 50; acc_m[3][2] = -300;
    launch(1, 0, 1);
    drain(100, NR, -1);
    check("relu_neg", got[0][7:0], 8'h00);
    check("relu_pos", got[0][15:8], 8'd50);
    check("relu_sat_neg", got[3][23:16], 8'h00);
    @(negedge clk);

    // Random backpressure
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) acc_m[r][c] = (r*37 + c*53) % 400 - 200;
    launch(2, 1, 0);
    drain(40, NR, -1);
    @(negedge clk);

    // Snapshot isolation and start while busy
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) acc_m[r][c] = r*NC + c - 50;
    launch(3, 1, 1);
    c_in_flat = '1;
    scale     = 16'd9;
    shift     = 5'd0;
    relu_en   = 1'b0;
    drain(60, NR, 5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("snap_no_extra_done", done, 1'b0);
      check("snap_idle_busy", busy, 1'b0);
      check("snap_idle_valid", out_valid, 1'b0);
    end

    // Back-to-back: second start lands in the done cycle
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) acc_m[r][c] = r - c*9;
    @(negedge clk);
    launch(5, 2, 0);
    drain(100, NR, -1);
    check("b2b_done_cycle", done, 1'b1);
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) acc_m[r][c] = c*r*3 - 60;
    launch(1, 0, 1);
    check("b2b_busy", busy, 1'b1);
    drain(70, NR, -1);
    @(negedge clk);

    // Reset mid-drain after row 5 is accepted
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) acc_m[r][c] = r*NC + c - 100;
    launch(1, 0, 0);
    drain(100, 6, -1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_row", out_row, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    launch(1, 0, 0);
    drain(100, NR, -1);
    check("post_rst_r0c0", got[0][7:0], 8'h9c);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
